// File: rtl/saturn_bus_sequencer.sv
// Saturn bus sequencer: owns the multi-phase bus cycle, a command/data program FIFO
// and a counted read engine with a one-clock read-valid strobe.
module saturn_bus_sequencer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned PHASES     = 4,
  parameter int unsigned READ_PHASE = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_clk_en,
  output logic [PHASES-1:0]         o_phases,
  output logic [$clog2(PHASES)-1:0] o_phase,
  output logic [31:0]               o_cycle_ctr,
  input  logic                      i_prog_valid,
  input  logic                      i_prog_is_cmd,
  input  logic [DATA_W-1:0]         i_prog_data,
  output logic                      o_prog_ready,
  input  logic                      i_read_start,
  input  logic [7:0]                i_read_count,
  output logic [7:0]                o_reads_left,
  input  logic                      i_abort,
  output logic                      o_bus_clk_en,
  output logic                      o_bus_is_data,
  output logic [DATA_W-1:0]         o_bus_nibble_out,
  input  logic [DATA_W-1:0]         i_bus_nibble_in,
  output logic                      o_read_valid,
  output logic [DATA_W-1:0]         o_read_data,
  output logic                      o_busy,
  output logic                      o_error,
  output logic                      o_halt
);

  localparam int unsigned PW = $clog2(PHASES);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {CycIdle, CycWrite, CycRead} cyc_e;

  logic [PW-1:0]   ph;
  cyc_e            cyc;
  logic [AW:0]     count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [DATA_W:0] mem [DEPTH];
  logic [DATA_W:0] head;

  logic ph0, ph1, ph_read, ph_last;
  logic fifo_empty, push, pop, issue_read;

  assign ph0     = i_clk_en && (ph == '0);
  assign ph1     = i_clk_en && (ph == PW'(1));
  assign ph_read = i_clk_en && (ph == PW'(READ_PHASE));
  assign ph_last = (ph == PW'(PHASES - 1));

  assign fifo_empty   = (count == '0);
  assign o_prog_ready = (count != (AW + 1)'(DEPTH));
  assign head         = mem[rd_ptr];

  // Abort swallows any push on the same edge; a queued write always beats a read.
  assign push       = i_prog_valid && o_prog_ready && !i_abort;
  assign pop        = ph0 && !fifo_empty;
  assign issue_read = ph0 && fifo_empty && (o_reads_left != 8'd0);

  assign o_phases = PHASES'(1) << ph;
  assign o_phase  = ph;
  assign o_halt   = o_error;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_prog_is_cmd, i_prog_data};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ph               <= '0;
      cyc              <= CycIdle;
      o_cycle_ctr      <= '0;
      count            <= '0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      o_reads_left     <= '0;
      o_bus_clk_en     <= 1'b0;
      o_bus_is_data    <= 1'b0;
      o_bus_nibble_out <= '0;
      o_read_valid     <= 1'b0;
      o_read_data      <= '0;
      o_busy           <= 1'b1;
      o_error          <= 1'b0;
    end else begin
      if (i_clk_en) begin
        ph <= ph_last ? '0 : ph + PW'(1);
        if (ph_last) o_cycle_ctr <= o_cycle_ctr + 32'd1;
      end

      if (pop) begin
        o_bus_nibble_out <= head[DATA_W-1:0];
        o_bus_is_data    <= !head[DATA_W];
        o_bus_clk_en     <= 1'b1;
        o_busy           <= 1'b1;
        cyc              <= CycWrite;
      end else if (issue_read) begin
        o_bus_is_data    <= 1'b1;
        o_bus_clk_en     <= 1'b1;
        cyc              <= CycRead;
      end else if (ph0) begin
        cyc              <= CycIdle;
      end

      if (ph1) o_bus_clk_en <= 1'b0;

      o_read_valid <= 1'b0;
      if (ph_read) begin
        if (cyc == CycRead) begin
          o_read_data  <= i_bus_nibble_in;
          o_read_valid <= 1'b1;
        end
        if (fifo_empty) o_busy <= 1'b0;
      end

      if (i_abort) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW + 1)'(1);
          2'b01:   count <= count - (AW + 1)'(1);
          default: ;
        endcase
      end

      if (i_prog_valid && !o_prog_ready && !i_abort) o_error <= 1'b1;

      // A fresh load wins over the phase-0 decrement of the same edge.
      if (i_abort)           o_reads_left <= '0;
      else if (i_read_start) o_reads_left <= i_read_count;
      else if (issue_read)   o_reads_left <= o_reads_left - 8'd1;
    end
  end

endmodule

// File: tb/tb_saturn_bus_sequencer.sv
// Scoreboard bench for saturn_bus_sequencer: expected strobes and read data are queued
// as stimulus is driven and retired by a negedge monitor.
module tb_saturn_bus_sequencer;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned DATA_W     = 4;
  localparam int unsigned PHASES     = 4;
  localparam int unsigned READ_PHASE = 2;

  logic                      i_clk = 1'b0;
  logic                      i_reset_n = 1'b0;
  logic                      i_clk_en = 1'b0;
  logic [PHASES-1:0]         o_phases;
  logic [$clog2(PHASES)-1:0] o_phase;
  logic [31:0]               o_cycle_ctr;
  logic                      i_prog_valid = 1'b0;
  logic                      i_prog_is_cmd = 1'b0;
  logic [DATA_W-1:0]         i_prog_data = '0;
  logic                      o_prog_ready;
  logic                      i_read_start = 1'b0;
  logic [7:0]                i_read_count = '0;
  logic [7:0]                o_reads_left;
  logic                      i_abort = 1'b0;
  logic                      o_bus_clk_en;
  logic                      o_bus_is_data;
  logic [DATA_W-1:0]         o_bus_nibble_out;
  logic [DATA_W-1:0]         i_bus_nibble_in = '0;
  logic                      o_read_valid;
  logic [DATA_W-1:0]         o_read_data;
  logic                      o_busy;
  logic                      o_error;
  logic                      o_halt;

  saturn_bus_sequencer #(
    .DEPTH      (DEPTH),
    .DATA_W     (DATA_W),
    .PHASES     (PHASES),
    .READ_PHASE (READ_PHASE)
  ) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_clk_en         (i_clk_en),
    .o_phases         (o_phases),
    .o_phase          (o_phase),
    .o_cycle_ctr      (o_cycle_ctr),
    .i_prog_valid     (i_prog_valid),
    .i_prog_is_cmd    (i_prog_is_cmd),
    .i_prog_data      (i_prog_data),
    .o_prog_ready     (o_prog_ready),
    .i_read_start     (i_read_start),
    .i_read_count     (i_read_count),
    .o_reads_left     (o_reads_left),
    .i_abort          (i_abort),
    .o_bus_clk_en     (o_bus_clk_en),
    .o_bus_is_data    (o_bus_is_data),
    .o_bus_nibble_out (o_bus_nibble_out),
    .i_bus_nibble_in  (i_bus_nibble_in),
    .o_read_valid     (o_read_valid),
    .o_read_data      (o_read_data),
    .o_busy           (o_busy),
    .o_error          (o_error),
    .o_halt           (o_halt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic              is_read;
    logic              is_data;
    logic [DATA_W-1:0] nibble;
  } strobe_t;

  strobe_t           exp_strobe_q[$];
  logic [DATA_W-1:0] exp_read_q[$];
  logic [DATA_W-1:0] supply_q[$];
  int                checks = 0;
  int                errors = 0;
  logic              strobe_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic is_cmd, input logic [DATA_W-1:0] data, input bit accept);
    strobe_t s;
    i_prog_valid  = 1'b1;
    i_prog_is_cmd = is_cmd;
    i_prog_data   = data;
    if (accept) begin
      s = '{is_read: 1'b0, is_data: !is_cmd, nibble: data};
      exp_strobe_q.push_back(s);
    end
    tick(1);
    i_prog_valid = 1'b0;
  endtask

  task automatic expect_read(input logic [DATA_W-1:0] value, input bit captured);
    strobe_t s;
    s = '{is_read: 1'b1, is_data: 1'b1, nibble: '0};
    exp_strobe_q.push_back(s);
    supply_q.push_back(value);
    if (captured) exp_read_q.push_back(value);
  endtask

  task automatic start_reads(input logic [7:0] n);
    i_read_start = 1'b1;
    i_read_count = n;
    tick(1);
    i_read_start = 1'b0;
  endtask

  // Retire strobes on their rising edge and read data on each valid pulse.
  always @(negedge i_clk) begin
    strobe_t e;
    if (o_bus_clk_en && !strobe_prev) begin
      if (exp_strobe_q.size() == 0) begin
        check("strobe_unexpected", 32'(1), 32'(0));
      end else begin
        e = exp_strobe_q.pop_front();
        check("strobe_is_data", 32'(o_bus_is_data), 32'(e.is_data));
        if (!e.is_read) check("strobe_nibble", 32'(o_bus_nibble_out), 32'(e.nibble));
        else if (supply_q.size() != 0) i_bus_nibble_in = supply_q.pop_front();
      end
    end
    strobe_prev = o_bus_clk_en;
    if (o_read_valid) begin
      if (exp_read_q.size() == 0) check("read_unexpected", 32'(1), 32'(0));
      else check("read_data", 32'(o_read_data), 32'(exp_read_q.pop_front()));
    end
  end

  initial begin
    // Reset values, then two idle bus cycles.
    tick(2);
    check("rst_phases", 32'(o_phases), 32'(1));
    check("rst_cycle_ctr", o_cycle_ctr, 32'(0));
    check("rst_busy", 32'(o_busy), 32'(1));
    check("rst_ready", 32'(o_prog_ready), 32'(1));
    check("rst_reads_left", 32'(o_reads_left), 32'(0));
    check("rst_error", 32'(o_error), 32'(0));
    i_reset_n = 1'b1;
    i_clk_en  = 1'b1;
    tick(2);
    check("idle_busy_ph1", 32'(o_busy), 32'(1));
    tick(1);
    check("idle_busy_ph2", 32'(o_busy), 32'(0));
    tick(5);
    check("idle_cycle_ctr", o_cycle_ctr, 32'(2));
    check("idle_phases", 32'(o_phases), 32'(1));

    // Write sequence.
    push(1'b1, 4'h5, 1'b1);
    push(1'b0, 4'hA, 1'b1);
    push(1'b0, 4'h3, 1'b1);
    tick(11);
    check("wr_busy_before_ph2", 32'(o_busy), 32'(1));
    check("wr_all_strobes", 32'(exp_strobe_q.size()), 32'(0));
    tick(1);
    check("wr_busy_cleared", 32'(o_busy), 32'(0));

    // Read burst of three.
    expect_read(4'h1, 1'b1);
    expect_read(4'h2, 1'b1);
    expect_read(4'h3, 1'b1);
    start_reads(8'd3);
    tick(1);
    check("rd_left_2", 32'(o_reads_left), 32'(2));
    tick(4);
    check("rd_left_1", 32'(o_reads_left), 32'(1));
    tick(4);
    check("rd_left_0", 32'(o_reads_left), 32'(0));
    tick(4);
    check("rd_all_returned", 32'(exp_read_q.size()), 32'(0));

    // Overflow with the phase frozen.
    i_clk_en = 1'b0;
    push(1'b1, 4'h1, 1'b1);
    push(1'b0, 4'h2, 1'b1);
    push(1'b0, 4'h4, 1'b1);
    push(1'b1, 4'h8, 1'b1);
    check("ovf_ready_full", 32'(o_prog_ready), 32'(0));
    check("ovf_no_error_yet", 32'(o_error), 32'(0));
    push(1'b0, 4'hF, 1'b0);
    check("ovf_error", 32'(o_error), 32'(1));
    check("ovf_halt", 32'(o_halt), 32'(1));
    check("ovf_phase_frozen", 32'(o_phase), 32'(1));
    i_clk_en = 1'b1;
    tick(20);
    check("ovf_four_strobes", 32'(exp_strobe_q.size()), 32'(0));
    check("ovf_ready_again", 32'(o_prog_ready), 32'(1));
    check("ovf_error_sticky", 32'(o_error), 32'(1));

    // A write pushed mid-burst goes ahead of the remaining reads.
    expect_read(4'h9, 1'b1);
    start_reads(8'd4);
    tick(3);
    check("pre_left_3", 32'(o_reads_left), 32'(3));
    push(1'b0, 4'h7, 1'b1);
    expect_read(4'hB, 1'b1);
    expect_read(4'hC, 1'b1);
    expect_read(4'hD, 1'b1);
    tick(3);
    check("pre_write_left", 32'(o_reads_left), 32'(3));
    check("pre_write_nibble", 32'(o_bus_nibble_out), 32'(7));
    tick(4);
    check("pre_resume_left", 32'(o_reads_left), 32'(2));
    tick(12);
    check("pre_left_done", 32'(o_reads_left), 32'(0));
    check("pre_strobes_done", 32'(exp_strobe_q.size()), 32'(0));
    check("pre_reads_done", 32'(exp_read_q.size()), 32'(0));

    // Abort with a read in flight, three writes queued and two reads left.
    expect_read(4'h6, 1'b1);
    start_reads(8'd3);
    tick(3);
    check("abt_left_2", 32'(o_reads_left), 32'(2));
    i_clk_en = 1'b0;
    push(1'b0, 4'h1, 1'b0);
    push(1'b0, 4'h2, 1'b0);
    push(1'b0, 4'h3, 1'b0);
    check("abt_strobe_held", 32'(o_bus_clk_en), 32'(1));
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    check("abt_left_cleared", 32'(o_reads_left), 32'(0));
    check("abt_ready", 32'(o_prog_ready), 32'(1));
    i_clk_en = 1'b1;
    tick(16);
    check("abt_read_finished", 32'(exp_read_q.size()), 32'(0));
    check("abt_no_more_strobes", 32'(exp_strobe_q.size()), 32'(0));
    check("abt_busy", 32'(o_busy), 32'(0));
    check("abt_error_kept", 32'(o_error), 32'(1));

    // Reset dropped during phase 1 of a read cycle.
    expect_read(4'hE, 1'b0);
    start_reads(8'd5);
    tick(3);
    check("mid_strobe_high", 32'(o_bus_clk_en), 32'(1));
    check("mid_left_4", 32'(o_reads_left), 32'(4));
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_strobe", 32'(o_bus_clk_en), 32'(0));
    check("mid_rst_phases", 32'(o_phases), 32'(1));
    check("mid_rst_left", 32'(o_reads_left), 32'(0));
    check("mid_rst_ctr", o_cycle_ctr, 32'(0));
    check("mid_rst_busy", 32'(o_busy), 32'(1));
    check("mid_rst_error", 32'(o_error), 32'(0));
    tick(3);
    check("mid_rst_no_read", 32'(o_read_valid), 32'(0));
    check("end_strobes_left", 32'(exp_strobe_q.size()), 32'(0));
    check("end_reads_left", 32'(exp_read_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
